ame_approx_mul: RTL and testbench

//  Downstream stage of the approximate-number unit. Consumes two approximated magnitudes (few set

---
 rtl/ame_pkg.sv | 11 +
 rtl/ame_approx_mul_if.sv | 28 ++
 rtl/ame_lsb_sel.sv | 44 ++++
 rtl/ame_approx_mul.sv | 103 ++++++++++
 tb/tb_ame_approx_mul.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/ame_pkg.sv
// Shared types and constants for the approximate-number multiplier stage.
package ame_pkg;

  localparam int AME_DATA_BITS = 64;

  typedef enum logic {
    AME_IDLE = 1'b0,
    AME_RUN  = 1'b1
  } ame_mul_state_t;

endpackage

// File: rtl/ame_approx_mul_if.sv
// Operand/result bundle between the approximation stage, the multiplier and the cost accumulator.
interface ame_approx_mul_if #(
  parameter int COMP_DATA_BITS = ame_pkg::AME_DATA_BITS
) ();

  localparam int PROD_BITS = 2 * COMP_DATA_BITS;

  logic                      comp_init_i;
  logic [COMP_DATA_BITS-1:0] a_data_i;
  logic                      a_sign_i;
  logic [COMP_DATA_BITS-1:0] b_data_i;
  logic                      b_sign_i;
  logic                      busy_o;
  logic                      comp_done_o;
  logic [PROD_BITS-1:0]      comp_data_o;
  logic                      comp_data_sign_o;

  modport master (
    output comp_init_i, a_data_i, a_sign_i, b_data_i, b_sign_i,
    input  busy_o, comp_done_o, comp_data_o, comp_data_sign_o
  );

  modport slave (
    input  comp_init_i, a_data_i, a_sign_i, b_data_i, b_sign_i,
    output busy_o, comp_done_o, comp_data_o, comp_data_sign_o
  );

endinterface

// File: rtl/ame_lsb_sel.sv
// Lowest-set-bit selector: one-hot isolate, binary index and empty flag.
// Index is resolved per 8-bit group first, then the lowest non-empty group wins.
module ame_lsb_sel #(
  parameter int W = 64
) (
  input  logic [W-1:0]         data_i,
  output logic [W-1:0]         onehot_o,
  output logic [$clog2(W)-1:0] idx_o,
  output logic                 none_o
);

  localparam int NG    = W / 8;
  localparam int IDX_W = $clog2(W);

  logic [NG-1:0] grp_nz;
  logic [2:0]    grp_idx [NG];

  always_comb begin
    grp_nz = '0;
    for (int g = 0; g < NG; g++) begin
      grp_nz[g]  = |data_i[g*8 +: 8];
      grp_idx[g] = 3'd0;
      for (int b = 7; b >= 0; b--) begin
        if (data_i[g*8 + b]) begin
          grp_idx[g] = 3'(b);
        end
      end
    end
  end

  always_comb begin
    idx_o = '0;
    // Walk from the top so the lowest non-empty group has the final say.
    for (int g = NG - 1; g >= 0; g--) begin
      if (grp_nz[g]) begin
        idx_o = IDX_W'(g * 8) + IDX_W'(grp_idx[g]);
      end
    end
  end

  assign onehot_o = data_i & (~data_i + W'(1));
  assign none_o   = ~|grp_nz;

endmodule

// File: rtl/ame_approx_mul.sv
// Sparse shift-add multiplier: one accumulate cycle per set bit of B, sign/magnitude result.
//   state    | meaning
//   AME_IDLE | waiting for comp_init_i; result registers hold the last product
//   AME_RUN  | adding A shifted by each remaining set bit of B; done when none left
module ame_approx_mul
  import ame_pkg::*;
#(
  parameter int COMP_DATA_BITS = AME_DATA_BITS,
  parameter int PROD_BITS      = 2 * COMP_DATA_BITS
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  ame_approx_mul_if.slave   bus
);

  localparam int IDX_W = $clog2(COMP_DATA_BITS);

  ame_mul_state_t            state_q, state_d;
  logic [PROD_BITS-1:0]      a_q, a_d;
  logic [COMP_DATA_BITS-1:0] b_rem_q, b_rem_d;
  logic                      sign_q, sign_d;
  logic [PROD_BITS-1:0]      acc_q, acc_d;
  logic [PROD_BITS-1:0]      comp_data_q, comp_data_d;
  logic                      comp_data_sign_q, comp_data_sign_d;
  logic                      comp_done_q, comp_done_d;

  logic [COMP_DATA_BITS-1:0] lsb_onehot;
  logic [IDX_W-1:0]          lsb_idx;
  logic                      lsb_none;

  ame_lsb_sel #(
    .W (COMP_DATA_BITS)
  ) u_lsb_sel (
    .data_i   (b_rem_q),
    .onehot_o (lsb_onehot),
    .idx_o    (lsb_idx),
    .none_o   (lsb_none)
  );

  always_comb begin
    state_d          = state_q;
    a_d              = a_q;
    b_rem_d          = b_rem_q;
    sign_d           = sign_q;
    acc_d            = acc_q;
    comp_data_d      = comp_data_q;
    comp_data_sign_d = comp_data_sign_q;
    comp_done_d      = 1'b0;

    unique case (state_q)
      AME_IDLE: begin
        if (bus.comp_init_i) begin
          a_d     = PROD_BITS'(bus.a_data_i);
          b_rem_d = bus.b_data_i;
          sign_d  = bus.a_sign_i ^ bus.b_sign_i;
          acc_d   = '0;
          state_d = AME_RUN;
        end
      end
      AME_RUN: begin
        if (!lsb_none) begin
          acc_d   = acc_q + (a_q << lsb_idx);
          b_rem_d = b_rem_q & ~lsb_onehot;
        end else begin
          // A zero magnitude never carries a negative sign downstream.
          comp_data_d      = acc_q;
          comp_data_sign_d = sign_q & (|acc_q);
          comp_done_d      = 1'b1;
          state_d          = AME_IDLE;
        end
      end
      default: state_d = AME_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q          <= AME_IDLE;
      a_q              <= '0;
      b_rem_q          <= '0;
      sign_q           <= 1'b0;
      acc_q            <= '0;
      comp_data_q      <= '0;
      comp_data_sign_q <= 1'b0;
      comp_done_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      a_q              <= a_d;
      b_rem_q          <= b_rem_d;
      sign_q           <= sign_d;
      acc_q            <= acc_d;
      comp_data_q      <= comp_data_d;
      comp_data_sign_q <= comp_data_sign_d;
      comp_done_q      <= comp_done_d;
    end
  end

  assign bus.busy_o           = (state_q == AME_RUN);
  assign bus.comp_done_o      = comp_done_q;
  assign bus.comp_data_o      = comp_data_q;
  assign bus.comp_data_sign_o = comp_data_sign_q;

endmodule

// File: tb/tb_ame_approx_mul.sv
// Randomized and directed bench for ame_approx_mul against a cycle-count/product reference model.
module tb_ame_approx_mul;

  localparam int DW = 64;
  localparam int PW = 2 * DW;

  logic clk_i;
  logic rst_n_i;

  ame_approx_mul_if #(.COMP_DATA_BITS(DW)) ifc ();

  ame_approx_mul #(
    .COMP_DATA_BITS (DW),
    .PROD_BITS      (PW)
  ) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (ifc.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: product by plain multiplication, completion after popcount(B)+1 edges.
  logic          m_busy;
  int            m_left;
  logic [PW-1:0] m_prod;
  logic          m_sign;
  logic          exp_done;
  logic [PW-1:0] exp_data;
  logic          exp_sign;

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_busy   <= 1'b0;
      m_left   <= 0;
      m_prod   <= '0;
      m_sign   <= 1'b0;
      exp_done <= 1'b0;
      exp_data <= '0;
      exp_sign <= 1'b0;
    end else begin
      exp_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 0) begin
          exp_done <= 1'b1;
          exp_data <= m_prod;
          exp_sign <= m_sign;
          m_busy   <= 1'b0;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (ifc.comp_init_i) begin
        m_busy <= 1'b1;
        m_left <= $countones(ifc.b_data_i);
        m_prod <= PW'(ifc.a_data_i) * PW'(ifc.b_data_i);
        m_sign <= (ifc.a_sign_i ^ ifc.b_sign_i) && (ifc.a_data_i != '0) && (ifc.b_data_i != '0);
      end
    end
  end

  always @(negedge clk_i) begin
    chk("busy",      PW'(ifc.busy_o),           PW'(m_busy));
    chk("done",      PW'(ifc.comp_done_o),      PW'(exp_done));
    chk("data",      ifc.comp_data_o,           exp_data);
    chk("data_sign", PW'(ifc.comp_data_sign_o), PW'(exp_sign));
  end

  function automatic logic [DW-1:0] sparse();
    logic [DW-1:0] v;
    int n;
    v = '0;
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) v[$urandom_range(0, DW-1)] = 1'b1;
    return v;
  endfunction

  // Start one op, wait (bounded) for done, pin latency and result to hand-computed values.
  // An extra init pulse is injected so that it is high at edge T+inject.
  task automatic do_op(input logic [DW-1:0] a, input logic as, input logic [DW-1:0] b,
                       input logic bs, input int exp_lat, input logic [PW-1:0] exp_d,
                       input logic exp_s, input int inject, input string name);
    int lat;
    bit got;
    @(negedge clk_i); #1;
    ifc.a_data_i    = a;
    ifc.a_sign_i    = as;
    ifc.b_data_i    = b;
    ifc.b_sign_i    = bs;
    ifc.comp_init_i = 1'b1;
    @(posedge clk_i); #1;
    ifc.comp_init_i = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(posedge clk_i);
      lat++;
      #1;
      if (ifc.comp_done_o) begin
        got = 1'b1;
      end else if (lat == inject - 1) begin
        ifc.a_data_i    = 64'd1;
        ifc.b_data_i    = 64'd1;
        ifc.comp_init_i = 1'b1;
      end else if (lat == inject) begin
        ifc.comp_init_i = 1'b0;
      end
    end
    ifc.comp_init_i = 1'b0;
    chk({name, "_done_seen"}, PW'(got), PW'(1));
    chk({name, "_latency"},   PW'(lat), PW'(exp_lat));
    chk({name, "_data"},      ifc.comp_data_o, exp_d);
    chk({name, "_sign"},      PW'(ifc.comp_data_sign_o), PW'(exp_s));
  endtask

  initial begin
    rst_n_i         = 1'b0;
    ifc.comp_init_i = 1'b0;
    ifc.a_data_i    = '0;
    ifc.a_sign_i    = 1'b0;
    ifc.b_data_i    = '0;
    ifc.b_sign_i    = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_busy", PW'(ifc.busy_o), PW'(0));
    chk("rst_data", ifc.comp_data_o, PW'(0));
    #1 rst_n_i = 1'b1;

    do_op(64'd3, 1'b0, 64'd5, 1'b0, 3, PW'(15), 1'b0, -5, "a3b5");
    do_op(64'h8000_0000_0000_0000, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 2,
          128'h4000_0000_0000_0000_0000_0000_0000_0000, 1'b1, -5, "msb");
    do_op(64'd7, 1'b1, 64'd0, 1'b1, 1, PW'(0), 1'b0, -5, "b_zero");
    do_op(64'd0, 1'b1, 64'hFF, 1'b0, 9, PW'(0), 1'b0, -5, "a_zero");
    do_op('1, 1'b0, '1, 1'b0, 65, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 1'b0, 10,
          "all_ones");
    // Issued right after the previous done: exercises back-to-back acceptance.
    do_op(64'd9, 1'b1, 64'd6, 1'b0, 3, PW'(54), 1'b1, -5, "b2b");

    // Reset in the middle of a 4-set-bit operation.
    @(negedge clk_i); #1;
    ifc.a_data_i    = 64'd5;
    ifc.b_data_i    = 64'hF;
    ifc.a_sign_i    = 1'b1;
    ifc.comp_init_i = 1'b1;
    @(posedge clk_i); #1;
    ifc.comp_init_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i); #1;
    rst_n_i = 1'b0;
    #1;
    chk("midrst_busy", PW'(ifc.busy_o), PW'(0));
    chk("midrst_done", PW'(ifc.comp_done_o), PW'(0));
    chk("midrst_data", ifc.comp_data_o, PW'(0));
    chk("midrst_sign", PW'(ifc.comp_data_sign_o), PW'(0));
    repeat (2) @(negedge clk_i);
    #1 rst_n_i = 1'b1;
    repeat (6) @(negedge clk_i);
    do_op(64'd6, 1'b0, 64'd3, 1'b1, 3, PW'(18), 1'b1, -5, "after_rst");

    // Random phase: init toggled freely, including while busy; the model decides acceptance.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk_i); #1;
      ifc.comp_init_i = ($urandom_range(0, 3) == 0);
      ifc.a_data_i    = sparse();
      ifc.b_data_i    = sparse();
      ifc.a_sign_i    = 1'($urandom_range(0, 1));
      ifc.b_sign_i    = 1'($urandom_range(0, 1));
    end
    @(negedge clk_i); #1;
    ifc.comp_init_i = 1'b0;
    repeat (10) @(negedge clk_i);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
